// File: rtl/ecp_proj_to_aff.sv
// Projective/Jacobian (X,Y,Z) to affine (x,y) converter over GF(p): one binary
// extended-Euclid inversion of Z followed by shared bit-serial modular multiplies.
module ecp_proj_to_aff #(
  parameter int WIDTH    = 256,
  parameter bit JACOBIAN = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] AX,
  output logic [WIDTH-1:0] AY,
  output logic             o_inf,
  output logic             o_done
);

  localparam int CAP = 4 * WIDTH;
  localparam int CW  = $clog2(CAP + 1);
  localparam int BW  = $clog2(WIDTH);
  localparam logic [1:0] LAST_IDX = JACOBIAN ? 2'd3 : 2'd1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_INV, S_MLOAD, S_MSTEP, S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] p_r, x_r, y_r, z_r;
  logic [WIDTH-1:0] u, v, x1, x2, zi, zp;
  logic [WIDTH-1:0] acc, mul_a, mul_b;
  logic [BW-1:0]    bit_cnt;
  logic [1:0]       prod_idx;
  logic [CW-1:0]    inv_cnt;
  logic [WIDTH-1:0] op_a, op_b, step_res;

  // Halve modulo an odd m: odd values get m added first, the sum needs WIDTH+1 bits.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = a[0] ? ({1'b0, a} + {1'b0, m}) : {1'b0, a};
    return s[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] d;
    d = a - b;
    if (a < b) d = d + m;
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] a_acc,
                                                input logic [WIDTH-1:0] a_add,
                                                input logic             bit_set,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] t;
    t = {a_acc, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (bit_set) begin
      t = t + {1'b0, a_add};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[WIDTH-1:0];
  endfunction

  // Product schedule: projective needs X*zi, Y*zi; Jacobian builds zi^2 and zi^3 in zp.
  always_comb begin
    op_a = x_r;
    op_b = zi;
    if (JACOBIAN) begin
      case (prod_idx)
        2'd0:    begin op_a = zi;  op_b = zi; end
        2'd1:    begin op_a = x_r; op_b = zp; end
        2'd2:    begin op_a = zp;  op_b = zi; end
        default: begin op_a = y_r; op_b = zp; end
      endcase
    end else if (prod_idx[0]) begin
      op_a = y_r;
    end
  end

  assign step_res = mul_step(acc, mul_a, mul_b[bit_cnt], p_r);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      p_r      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      zi       <= '0;
      zp       <= '0;
      acc      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      bit_cnt  <= '0;
      prod_idx <= '0;
      inv_cnt  <= '0;
      AX       <= '0;
      AY       <= '0;
      o_inf    <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            p_r   <= p;
            x_r   <= X;
            y_r   <= Y;
            z_r   <= Z;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (z_r == '0) begin
            AX     <= '0;
            AY     <= '0;
            o_inf  <= 1'b1;
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            o_inf   <= 1'b0;
            u       <= z_r;
            v       <= p_r;
            x1      <= ONE;
            x2      <= '0;
            inv_cnt <= '0;
            state   <= S_INV;
          end
        end
        // The cycle cap guarantees exit even for even p or out-of-range operands.
        S_INV: begin
          inv_cnt <= inv_cnt + 1'b1;
          if (u == ONE || v == ONE) begin
            zi       <= (u == ONE) ? x1 : x2;
            prod_idx <= '0;
            state    <= S_MLOAD;
          end else if (inv_cnt == CW'(CAP - 1)) begin
            zi       <= x1;
            prod_idx <= '0;
            state    <= S_MLOAD;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= half_mod(x1, p_r);
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= half_mod(x2, p_r);
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= sub_mod(x1, x2, p_r);
          end else begin
            v  <= v - u;
            x2 <= sub_mod(x2, x1, p_r);
          end
        end
        S_MLOAD: begin
          acc     <= '0;
          mul_a   <= op_a;
          mul_b   <= op_b;
          bit_cnt <= BW'(WIDTH - 1);
          state   <= S_MSTEP;
        end
        S_MSTEP: begin
          acc     <= step_res;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            if (JACOBIAN) begin
              case (prod_idx)
                2'd0, 2'd2: zp <= step_res;
                2'd1:       AX <= step_res;
                default:    AY <= step_res;
              endcase
            end else if (prod_idx[0]) begin
              AY <= step_res;
            end else begin
              AX <= step_res;
            end
            if (prod_idx == LAST_IDX) begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              prod_idx <= prod_idx + 1'b1;
              state    <= S_MLOAD;
            end
          end
        end
        S_DONE: begin
          if (!i_start) begin
            o_done <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecp_proj_to_aff.sv
// Self-checking bench for ecp_proj_to_aff: directed cases plus random points
// checked against a Fermat-inverse reference model, for both coordinate systems.
module tb_ecp_proj_to_aff;

  localparam int W     = 16;
  localparam int BOUND = 2 + 4 * W + 4 * (W + 1);
  localparam int MAXC  = BOUND + 10;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         start0 = 1'b0;
  logic         start1 = 1'b0;
  logic [W-1:0] p = '0, X = '0, Y = '0, Z = '0;
  logic [W-1:0] ax0, ay0, ax1, ay1;
  logic         inf0, done0, inf1, done1;

  int assert_count = 0;
  int fail_count   = 0;
  int lat;

  always #5 i_clk = ~i_clk;

  ecp_proj_to_aff #(.WIDTH(W), .JACOBIAN(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start0),
    .p(p), .X(X), .Y(Y), .Z(Z),
    .AX(ax0), .AY(ay0), .o_inf(inf0), .o_done(done0)
  );

  ecp_proj_to_aff #(.WIDTH(W), .JACOBIAN(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start1),
    .p(p), .X(X), .Y(Y), .Z(Z),
    .AX(ax1), .AY(ay1), .o_inf(inf1), .o_done(done1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint mod_pow(input longint b, input longint e, input longint m);
    longint r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Launch one conversion; without hold, start drops right after acceptance.
  task automatic applyStimulus(input bit jac, input int pp, input int xx, input int yy,
                               input int zz, input bit hold, output int cycles);
    bit seen = 1'b0;
    @(negedge i_clk);
    p = pp[W-1:0];
    X = xx[W-1:0];
    Y = yy[W-1:0];
    Z = zz[W-1:0];
    if (jac) start1 = 1'b1;
    else     start0 = 1'b1;
    cycles = 0;
    while (!seen && cycles < MAXC) begin
      @(posedge i_clk);
      cycles++;
      @(negedge i_clk);
      if (!hold) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      seen = jac ? done1 : done0;
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic checkResult(input bit jac, input int pp, input int xx, input int yy, input int zz);
    longint ex, ey, zinv, zk;
    bit     einf;
    if (zz == 0) begin
      ex = 0; ey = 0; einf = 1'b1;
    end else begin
      einf = 1'b0;
      zinv = mod_pow(zz, pp - 2, pp);
      if (jac) begin
        zk = (zinv * zinv) % pp;
        ex = (xx * zk) % pp;
        ey = (yy * ((zk * zinv) % pp)) % pp;
      end else begin
        ex = (xx * zinv) % pp;
        ey = (yy * zinv) % pp;
      end
    end
    checkOutput(jac ? "jac_AX" : "proj_AX", jac ? ax1 : ax0, ex);
    checkOutput(jac ? "jac_AY" : "proj_AY", jac ? ay1 : ay0, ey);
    checkOutput(jac ? "jac_inf" : "proj_inf", jac ? inf1 : inf0, einf);
  endtask

  // Close a run: held start keeps DONE, release drops o_done one cycle later.
  task automatic finishOp(input bit jac, input bit hold);
    if (hold) begin
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("done_held", jac ? done1 : done0, 1);
      start0 = 1'b0;
      start1 = 1'b0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("done_release", jac ? done1 : done0, 0);
  endtask

  initial begin
    int primes[8] = '{3, 23, 233, 251, 7919, 40009, 65519, 65521};
    $display("[TB] start");
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("reset_AX", ax0, 0);
    checkOutput("reset_AY", ay1, 0);
    checkOutput("reset_inf", inf0, 0);
    checkOutput("reset_done0", done0, 0);
    checkOutput("reset_done1", done1, 0);
    i_rst_n = 1'b1;

    applyStimulus(1'b0, 23, 10, 11, 2, 1'b1, lat);
    checkOutput("t1_AX", ax0, 5);
    checkOutput("t1_AY", ay0, 17);
    checkOutput("t1_inf", inf0, 0);
    finishOp(1'b0, 1'b1);

    applyStimulus(1'b0, 233, 182, 56, 232, 1'b1, lat);
    checkOutput("t2a_AX", ax0, 51);
    checkOutput("t2a_AY", ay0, 177);
    finishOp(1'b0, 1'b1);
    applyStimulus(1'b0, 233, 51, 177, 1, 1'b1, lat);
    checkOutput("t2b_AX", ax0, 51);
    checkOutput("t2b_AY", ay0, 177);
    finishOp(1'b0, 1'b1);

    applyStimulus(1'b1, 23, 20, 21, 2, 1'b1, lat);
    checkOutput("t3_AX", ax1, 5);
    checkOutput("t3_AY", ay1, 17);
    checkOutput("t3_latency_ok", lat <= BOUND, 1);
    finishOp(1'b1, 1'b1);

    // Reset while dut0 sits in the inversion loop; it still holds 51/177 from before.
    @(negedge i_clk);
    p = 23; X = 10; Y = 11; Z = 2;
    start0 = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_AX", ax0, 0);
    checkOutput("t5_rst_AY", ay0, 0);
    checkOutput("t5_rst_done", done0, 0);
    start0 = 1'b0;
    @(negedge i_clk);
    checkOutput("t5_rst_done_hold", done0, 0);
    i_rst_n = 1'b1;
    applyStimulus(1'b0, 23, 10, 11, 2, 1'b1, lat);
    checkOutput("t5_AX", ax0, 5);
    checkOutput("t5_AY", ay0, 17);
    finishOp(1'b0, 1'b1);

    applyStimulus(1'b0, 23, 7, 13, 0, 1'b1, lat);
    checkOutput("t4_inf", inf0, 1);
    checkOutput("t4_AX", ax0, 0);
    checkOutput("t4_AY", ay0, 0);
    checkOutput("t4_latency", lat, 2);
    finishOp(1'b0, 1'b1);

    applyStimulus(1'b1, 23, 7, 13, 0, 1'b0, lat);
    checkResult(1'b1, 23, 7, 13, 0);
    finishOp(1'b1, 1'b0);

    applyStimulus(1'b0, 23, 10, 11, 2, 1'b0, lat);
    checkOutput("t6_AX", ax0, 5);
    checkOutput("t6_AY", ay0, 17);
    finishOp(1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int pp, xx, yy, zz;
      bit jac, hold;
      pp   = primes[$urandom_range(7, 0)];
      xx   = int'($urandom_range(pp - 1, 0));
      yy   = int'($urandom_range(pp - 1, 0));
      zz   = int'($urandom_range(pp - 1, 1));
      jac  = i[0];
      hold = 1'($urandom_range(1, 0));
      applyStimulus(jac, pp, xx, yy, zz, hold, lat);
      checkResult(jac, pp, xx, yy, zz);
      checkOutput("rand_latency_ok", lat <= BOUND, 1);
      finishOp(jac, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ecp_proj_to_aff.md
Name: ecp_proj_to_aff

Overview:
- Converts a projective/Jacobian point (X, Y, Z) over GF(p) to affine (x, y). It is the decoding end of the point representation that the point adder produces.
- Sits after ECPA in the scalar-multiply datapath. It takes ECPA's X3/Y3/Z3 and p directly and presents affine coordinates to the host.
- Datapath: one modular inversion (binary extended Euclid), then bit-serial modular multiplications.

Parameters:
WIDTH, 256, operand/modulus width in bits
JACOBIAN, 0, 0: x=X/Z, y=Y/Z (standard projective); 1: x=X/Z^2, y=Y/Z^3

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  level request; accepted in IDLE
p  input  WIDTH  odd prime modulus, p>2
X  input  WIDTH  projective X, must be < p
Y  input  WIDTH  projective Y, must be < p
Z  input  WIDTH  projective Z, must be < p
AX  output  WIDTH  affine x
AY  output  WIDTH  affine y
o_inf  output  1  point at infinity (Z==0)
o_done  output  1  result valid

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; AX=AY=0; o_inf=0; o_done=0; all internal registers 0. Reset mid-operation aborts immediately. The next start is served normally.
- Operand capture: in IDLE with i_start=1, p/X/Y/Z are registered and the FSM enters CHECK. Input changes after capture are ignored.
- CHECK (1 cycle):
  - Z==0: AX=AY=0, o_inf=1, go to DONE.
  - Otherwise: o_inf=0, init inversion u=Z, v=p, x1=1, x2=0, go to INV.
- INV, one action per cycle, in priority order:
  - (a) u==1 or v==1: zi = (u==1)?x1:x2, go to MUL.
  - (b) u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+p)>>1. The sum is WIDTH+1 bits.
  - (c) v even: same halving on v/x2.
  - (d) u>=v: u=u-v, x1=x1-x2 mod p (add p on borrow).
  - (e) else: v=v-u, x2=x2-x1 mod p.
  - Completes within 4*WIDTH cycles.
- MUL: shared bit-serial modular multiplier, MSB-first interleaved.
  - acc=2*acc mod p, then if bit set, acc=acc+a mod p. Each step uses a conditional subtract of p.
  - Exactly WIDTH cycles per product, plus 1 load cycle.
  - JACOBIAN=0 sequence: AX=X*zi, AY=Y*zi (2 products).
  - JACOBIAN=1 sequence: z2=zi*zi, AX=X*z2, z3=z2*zi, AY=Y*z3 (4 products).
  - AX/AY hold previous values until written. Both are final on DONE entry.
- DONE:
  - o_done=1; AX/AY/o_inf stable.
  - Stays in DONE while i_start=1. When i_start=0, o_done goes to 0 next cycle and the FSM returns to IDLE.
  - If i_start fell during computation, o_done is high for exactly one cycle.
- i_start deassert during CHECK/INV/MUL: ignored; the operation completes.
- i_start held high across DONE→IDLE is impossible. A new operation requires i_start low for at least one cycle.
- Operands >= p or even p: result unspecified. The FSM still reaches DONE within the bounded cycle count and never hangs. INV has a hard cap of 4*WIDTH cycles, then forces exit.
- Z==1: result equals (X, Y). Inversion exits on its first INV cycle.

Test Plan:
1. JACOBIAN=0, p=23, X=10, Y=11, Z=2, i_start held until o_done → AX=5, AY=17, o_inf=0. Release i_start → o_done=0 next cycle.
2. JACOBIAN=0, p=233, X=182, Y=56, Z=232 → AX=51, AY=177. Then p=233, X=51, Y=177, Z=1 → AX=51, AY=177. Both without intervening reset.
3. JACOBIAN=1, p=23, X=20, Y=21, Z=2 → AX=5, AY=17. Latency ≤ 1+1+4*WIDTH+4*(WIDTH+1) cycles.
4. p=23, X=7, Y=13, Z=0 → o_inf=1, AX=AY=0, o_done asserted 2 cycles after start accepted.
5. Pulse i_rst_n low during INV, then start p=23, X=10, Y=11, Z=2 → outputs 0 and o_done=0 during reset. Second run gives AX=5, AY=17.
6. Drop i_start one cycle after acceptance → o_done high exactly one cycle, AX/AY correct, FSM back in IDLE. Randomized Z in [1, p-1] checked against a software model.
